// File: rtl/seq_divider_15_pkg.sv
// Shared constants and state type for the 15-bit sequential divider.
package seq_divider_15_pkg;

    localparam int unsigned DIV_WIDTH = 15;
    localparam int unsigned DIV_ITER  = 15;
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider_15_if.sv
// Start/done handshake and operand/result bus between execute stage and divider.
interface seq_divider_15_if
    import seq_divider_15_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_15_sub.sv
// Combinational trial subtractor; counterpart of the ALU adder.
module sub_15
    import seq_divider_15_pkg::*;
#(
    parameter int unsigned W = DIV_WIDTH + 1
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] D,
    output logic         borrow_out
);

    // Borrow is the inverted carry of A - B computed one bit wider.
    assign {borrow_out, D} = {1'b0, A} - {1'b0, B};

endmodule

// File: rtl/seq_divider_15.sv
// Multi-cycle unsigned restoring divider: one trial subtract per cycle.
module seq_divider_15
    import seq_divider_15_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic              clk,
    input logic              rst_n,
    seq_divider_15_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DIV_ITER);

    div_state_e       state, state_next;

    logic [WIDTH:0]   r_reg, r_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             dz_reg, dz_next;

    logic             done_q, done_next;
    logic [WIDTH-1:0] quot_q, quot_next;
    logic [WIDTH-1:0] rem_q, rem_next;
    logic             dzo_q, dzo_next;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;

    // Shifting the full partial remainder drops its (always zero) top bit.
    assign r_shift = (r_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};

    sub_15 #(.W(WIDTH + 1)) u_sub (
        .A          (r_shift),
        .B          ({1'b0, d_reg}),
        .D          (diff),
        .borrow_out (borrow)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and datapath next values.
    always_comb begin
        state_next = state;
        r_next     = r_reg;
        q_next     = q_reg;
        d_next     = d_reg;
        cnt_next   = cnt;
        dz_next    = dz_reg;
        done_next  = 1'b0;
        quot_next  = quot_q;
        rem_next   = rem_q;
        dzo_next   = dzo_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        d_next     = bus.divisor;
                        r_next     = '0;
                        q_next     = bus.dividend;
                        cnt_next   = '0;
                        dz_next    = 1'b0;
                        state_next = CALC;
                    end else begin
                        q_next     = DIV0_QUOT;
                        r_next     = {1'b0, bus.dividend};
                        dz_next    = 1'b1;
                        state_next = FINISH;
                    end
                end
            end
            CALC: begin
                r_next   = borrow ? r_shift : diff;
                q_next   = {q_reg[WIDTH-2:0], ~borrow};
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DIV_ITER - 1)) state_next = FINISH;
            end
            FINISH: begin
                done_next  = 1'b1;
                quot_next  = q_reg;
                rem_next   = r_reg[WIDTH-1:0];
                dzo_next   = dz_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and result registers; results only change when done fires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg  <= '0;
            q_reg  <= '0;
            d_reg  <= '0;
            cnt    <= '0;
            dz_reg <= 1'b0;
            done_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            dzo_q  <= 1'b0;
        end else begin
            r_reg  <= r_next;
            q_reg  <= q_next;
            d_reg  <= d_next;
            cnt    <= cnt_next;
            dz_reg <= dz_next;
            done_q <= done_next;
            quot_q <= quot_next;
            rem_q  <= rem_next;
            dzo_q  <= dzo_next;
        end
    end

    assign bus.busy        = (state == CALC);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dzo_q;

endmodule

// File: tb/tb_seq_divider_15.sv
// Randomised self-checking bench for seq_divider_15 against a plain-arithmetic model.
module tb_seq_divider_15;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_divider_15_if #(.WIDTH(15)) bus ();

    seq_divider_15 #(.WIDTH(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One division with optional ignored start pulse or mid-run reset.
    task automatic run_div(input logic [14:0] a, input logic [14:0] b,
                           input int pulse_at, input int reset_at,
                           output logic [14:0] q_o, output logic [14:0] r_o);
        int          cyc;
        bit          busy_seen;
        bit          got_done;
        bit          late_done;
        logic [14:0] exp_q, exp_r;
        logic        exp_dz;
        if (b == 15'd0) begin
            exp_q = 15'h7FFF; exp_r = a; exp_dz = 1'b1;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_dz = 1'b0;
        end
        q_o = '0;
        r_o = '0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = 15'($urandom);
        bus.divisor  = 15'($urandom);
        cyc = 0; busy_seen = 0; got_done = 0;
        while (!got_done && cyc < 40) begin
            if (bus.busy) busy_seen = 1;
            if (reset_at > 0 && cyc == reset_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check("rst_quot", 32'(bus.quotient), 32'd0);
                check("rst_rem", 32'(bus.remainder), 32'd0);
                check("rst_dz", 32'(bus.div_by_zero), 32'd0);
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_done", 32'(bus.done), 32'd0);
                late_done = 0;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (bus.done) late_done = 1;
                end
                check("rst_no_done", 32'(late_done), 32'd0);
                return;
            end
            if (pulse_at > 0 && cyc == pulse_at) begin
                bus.start    = 1'b1;
                bus.dividend = 15'($urandom);
                bus.divisor  = 15'($urandom_range(1, 100));
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (bus.done) got_done = 1;
        end
        bus.start = 1'b0;
        if (reset_at > 0) check("rst_abort_early_done", 32'(got_done), 32'd0);
        check("latency", 32'(cyc), (b == 15'd0) ? 32'd1 : 32'd16);
        check("quotient", 32'(bus.quotient), 32'(exp_q));
        check("remainder", 32'(bus.remainder), 32'(exp_r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(exp_dz));
        check("busy_seen", 32'(busy_seen), (b == 15'd0) ? 32'd0 : 32'd1);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        q_o = bus.quotient;
        r_o = bus.remainder;
        @(posedge clk); #1;
        check("done_pulse", 32'(bus.done), 32'd0);
        check("hold_quot", 32'(bus.quotient), 32'(exp_q));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [14:0] a, b, q, r;
        int          t;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("init_quot", 32'(bus.quotient), 32'd0);
        check("init_rem", 32'(bus.remainder), 32'd0);
        check("init_dz", 32'(bus.div_by_zero), 32'd0);
        check("init_busy", 32'(bus.busy), 32'd0);
        check("init_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;

        run_div(15'h0034, 15'h0015, 0, 0, q, r);
        run_div(15'h7FFE, 15'h7FFE, 0, 0, q, r);
        run_div(15'h0034, 15'h7FFE, 0, 0, q, r);
        run_div(15'h7FFF, 15'h0001, 0, 0, q, r);
        run_div(15'h1234, 15'h0000, 0, 0, q, r);
        run_div(15'h0000, 15'h0003, 0, 0, q, r);

        // Start re-pulsed mid-calculation must not disturb the result.
        run_div(15'h4321, 15'h0017, 5, 0, q, r);
        // Reset at cycle 8 aborts the division.
        run_div(15'h5555, 15'h0033, 0, 8, q, r);

        // Start held high: results every 17 cycles.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 15'd100;
        bus.divisor  = 15'd7;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!bus.done && t < 40);
        check("b2b_first_quot", 32'(bus.quotient), 32'd14);
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!bus.done && t < 40);
        bus.start = 1'b0;
        check("b2b_period", 32'(t), 32'd17);
        check("b2b_second_rem", 32'(bus.remainder), 32'd2);
        @(posedge clk); #1;

        for (int i = 0; i < 200; i++) begin
            a = 15'($urandom);
            if (i % 4 == 0) b = 15'($urandom_range(1, 15));
            else            b = 15'($urandom_range(1, 32767));
            run_div(a, b, 0, 0, q, r);
            check("invariant", 32'(q) * 32'(b) + 32'(r), 32'(a));
            check("rem_lt_div", 32'(r < b), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
